spi_sd_cmd_engine: RTL and testbench
====================================

// Module: spi_sd_cmd_engine
// PURPOSE
//  Parametrised SPI-mode SD/SDHC command engine; next generation of the microSD SPI core.
//  Accepts a 48-bit command frame, shifts it out, polls for R1, and optionally receives a 32-bit trailer (R3/R7).
//  Also issues the power-up dummy-clock train.
//  Sits between the bootstrap/init sequencer and the card pins; programmable SCK divider and NCR timeout.
// PARAMETERS
//  CLK_DIV    4   SCK half-period in spi_clk_i cycles (>=1)
//  NCR_MAX    16  max response bytes polled before timeout (>=1)
//  INIT_CLKS  80  SCK rising edges in dummy mode, SS high (>=74)
// PORTS
//  spi_clk_i      in   1   system clock
//  spi_rst_i      in   1   asynchronous reset, active-high
//  spi_valid_i    in   1   request strobe; accepted when spi_ready_o=1
//  spi_ready_o    out  1   engine idle, can accept request
//  spi_cmd_i      in   48  command frame, bit 47 sent first (index, arg, CRC7, stop)
//  spi_rsplen_i   in   1   0: R1 only; 1: R1 + 32-bit trailer
//  spi_dummy_i    in   1   1: send INIT_CLKS dummy clocks instead of command
//  spi_r1_o       out  8   last R1 byte (8'hFF on timeout)
//  spi_data_o     out  32  last 32-bit trailer, MSB first as received
//  spi_done_o     out  1   one-cycle pulse: request finished
//  spi_timeout_o  out  1   set with done when no R1 within NCR_MAX bytes; cleared on next accept
//  MOSI           out  1   card data in
//  MISO           in   1   card data out
//  SCK_SPI        out  1   SPI clock, mode 0 (idle low)
//  SS             out  1   card select, active-low
// BEHAVIOUR
//  Reset (async): SCK_SPI=0, SS=1, MOSI=1, spi_ready_o=1, spi_done_o=0, spi_timeout_o=0, r1=8'h00, data=0; FSM->IDLE.
//  spi_ready_o = (state==IDLE). Accept on valid&ready: latch cmd/rsplen/dummy, clear timeout, ready drops next cycle.
//  spi_valid_i while busy is ignored; inputs are don't-care after accept.
//  SCK: divider counts 0..CLK_DIV-1; SCK toggles at terminal count, one toggle per CLK_DIV cycles; low between bits.
//  MISO is sampled on the spi_clk_i edge that raises SCK. MOSI updates on the edge that lowers SCK.
//  First MOSI bit is driven before the first rising edge.
//  FSM states:
//   IDLE:  SS=1, SCK=0, MOSI=1. Accept -> DUMMY if dummy=1, else SEND.
//   DUMMY: SS=1, MOSI=1, INIT_CLKS SCK pulses -> DONE. r1/data are left unchanged.
//   SEND:  SS=0; 48 bits MSB-first; after 48th falling edge -> POLL.
//   POLL:  MOSI=1; receive bytes. First byte with bit7=0 -> r1, then RECV if rsplen else GAP.
//          NCR_MAX bytes with bit7=1 -> r1=8'hFF, timeout=1, GAP (RECV skipped).
//   RECV:  32 bits MSB-first into data -> GAP.
//   GAP:   8 further SCK pulses, SS=0, MOSI=1 (card release) -> DONE.
//   DONE:  SS=1, done=1 for exactly one cycle -> IDLE (ready=1 the next cycle).
//  Latency, R1 in first polled byte, rsplen=0: accept to done = (48+8+8)*2*CLK_DIV + small fixed overhead (<=3 cycles).
//  Each additional polled byte adds 16*CLK_DIV cycles; rsplen=1 adds 64*CLK_DIV.
//  r1/data/timeout hold until the next request updates them; done is never asserted twice per request.
//  Reset mid-operation: immediate abort. Pins go to reset values same cycle; no done pulse; outputs are cleared.
//  CLK_DIV=1 supported (SCK = spi_clk_i/2). Byte/bit counters sized from parameters; no wrap beyond bounds.
// TESTING
//  1 Reset, CLK_DIV=4: SS=1, SCK=0, MOSI=1, ready=1, r1=0; valid held while reset is high has no effect.
//  2 CMD0 48'h400000000095, card model returns 0xFF then 0x01: MOSI stream matches, r1=8'h01, timeout=0.
//    done after (48+16+8)*8 cycles +-3.
//  3 CMD8 48'h48000001AA87, rsplen=1, card returns 0x01, 0x000001AA: r1=8'h01, data=32'h000001AA, one done pulse.
//  4 MISO stuck 1, NCR_MAX=16: exactly 16 bytes polled, r1=8'hFF, timeout=1, RECV skipped even with rsplen=1.
//  5 dummy=1: exactly 80 SCK rising edges with SS=1 and MOSI=1; then done; r1/data unchanged from the prior command.
//  6 Reset asserted at bit 20 of SEND: SS=1 and SCK=0 in the same cycle, no done; next CMD0 completes normally.
//    Also: valid pulsed mid-POLL is ignored.

Source files
------------

// File: rtl/spi_sd_cmd_engine.sv
// spi_sd_cmd_engine: SPI-mode SD command engine (48-bit frame out, R1 poll, optional 32-bit trailer, dummy clocks)
module spi_sd_cmd_engine #(
  parameter int CLK_DIV   = 4,
  parameter int NCR_MAX   = 16,
  parameter int INIT_CLKS = 80
) (
  input  logic        spi_clk_i,
  input  logic        spi_rst_i,
  input  logic        spi_valid_i,
  output logic        spi_ready_o,
  input  logic [47:0] spi_cmd_i,
  input  logic        spi_rsplen_i,
  input  logic        spi_dummy_i,
  output logic [7:0]  spi_r1_o,
  output logic [31:0] spi_data_o,
  output logic        spi_done_o,
  output logic        spi_timeout_o,
  output logic        MOSI,
  input  logic        MISO,
  output logic        SCK_SPI,
  output logic        SS
);
  typedef enum logic [2:0] {IDLE, DUMMY, SEND, POLL, RECV, GAP, DONE} state_t;
  localparam int BMAX = INIT_CLKS > 48 ? INIT_CLKS : 48;
  localparam int BW   = $clog2(BMAX);
  localparam int DW   = $clog2(CLK_DIV + 1);
  localparam int NW   = $clog2(NCR_MAX + 1);
  state_t          state_q, state_d;
  logic [DW-1:0]   div_q;
  logic [BW-1:0]   bit_q, bit_end;
  logic [NW-1:0]   byte_q;
  logic [47:0]     sh_q;
  logic [7:0]      r1_q;
  logic [31:0]     data_q;
  logic            sck_q, rsp_q, to_q;
  logic            active, tick, rise, fall, last, accept, r1_hit, ncr_end;
  assign spi_ready_o   = state_q == IDLE;
  assign spi_done_o    = state_q == DONE;
  assign spi_r1_o      = r1_q;
  assign spi_data_o    = data_q;
  assign spi_timeout_o = to_q;
  assign SCK_SPI       = sck_q;
  assign SS            = !(state_q inside {SEND, POLL, RECV, GAP});
  assign MOSI          = state_q == SEND ? sh_q[47] : 1'b1;
  assign active  = !(state_q inside {IDLE, DONE});
  assign tick    = active && div_q == DW'(CLK_DIV - 1);
  assign rise    = tick && !sck_q;
  assign fall    = tick && sck_q;
  assign bit_end = state_q == DUMMY ? BW'(INIT_CLKS - 1) : state_q == SEND ? BW'(47) :
                   state_q == RECV ? BW'(31) : BW'(7);
  assign last    = fall && bit_q == bit_end;
  assign accept  = spi_valid_i && spi_ready_o;
  assign r1_hit  = !sh_q[7];
  assign ncr_end = byte_q == NW'(NCR_MAX - 1);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? (spi_dummy_i ? DUMMY : SEND) : IDLE;
      DUMMY:   state_d = last ? DONE : DUMMY;
      SEND:    state_d = last ? POLL : SEND;
      POLL:    state_d = !last ? POLL : r1_hit ? (rsp_q ? RECV : GAP) : ncr_end ? GAP : POLL;
      RECV:    state_d = last ? GAP : RECV;
      GAP:     state_d = last ? DONE : GAP;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
    if (spi_rst_i) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      sh_q    <= '0;
      sck_q   <= 1'b0;
      rsp_q   <= 1'b0;
      to_q    <= 1'b0;
      r1_q    <= 8'h00;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= (tick || !active) ? '0 : div_q + 1'b1;
      sck_q   <= active && (tick ? !sck_q : sck_q);
      if (fall) bit_q <= last ? '0 : bit_q + 1'b1;
      // Command bits leave on falling edges; response bits enter on rising edges
      if (fall && state_q == SEND) sh_q <= {sh_q[46:0], 1'b1};
      if (rise && state_q inside {POLL, RECV}) sh_q <= {sh_q[46:0], MISO};
      if (last && state_q == POLL) begin
        if (r1_hit) r1_q <= sh_q[7:0];
        else if (ncr_end) begin
          r1_q <= 8'hFF;
          to_q <= 1'b1;
        end
        byte_q <= (r1_hit || ncr_end) ? '0 : byte_q + 1'b1;
      end
      if (last && state_q == RECV) data_q <= sh_q[31:0];
      if (accept) begin
        sh_q   <= spi_cmd_i;
        rsp_q  <= spi_rsplen_i;
        to_q   <= 1'b0;
        bit_q  <= '0;
        byte_q <= '0;
      end
    end
  end
endmodule

// File: tb/tb_spi_sd_cmd_engine.sv
// tb_spi_sd_cmd_engine: directed bench with a card model and a transaction-level expectation model
module tb_spi_sd_cmd_engine;
  localparam int D = 4, NCR = 16, IC = 80;
  logic clk = 1'b0, rst = 1'b1, valid = 1'b0, rsplen = 1'b0, dummy = 1'b0, miso = 1'b1;
  logic [47:0] cmd = '0;
  logic ready, done, tmo, mosi, sck, ss;
  logic [7:0] r1;
  logic [31:0] data;
  int nvec = 0, nerr = 0, rises = 0, done_cnt = 0;
  logic sck_prev = 1'b0, exp_dummy = 1'b0;
  logic [47:0] exp_cmd = '0;
  logic resp[$];
  logic [7:0] exp_r1 = 8'h00;
  logic [31:0] exp_data = '0;
  logic exp_to = 1'b0;
  int last_n, last_rises;

  spi_sd_cmd_engine #(.CLK_DIV(D), .NCR_MAX(NCR), .INIT_CLKS(IC)) dut (
    .spi_clk_i(clk), .spi_rst_i(rst), .spi_valid_i(valid), .spi_ready_o(ready),
    .spi_cmd_i(cmd), .spi_rsplen_i(rsplen), .spi_dummy_i(dummy), .spi_r1_o(r1),
    .spi_data_o(data), .spi_done_o(done), .spi_timeout_o(tmo),
    .MOSI(mosi), .MISO(miso), .SCK_SPI(sck), .SS(ss));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Card side and per-cycle pin checks
  initial forever begin
    int idx;
    @(negedge clk);
    if (ready) rises = 0;
    if (sck && !sck_prev) begin
      chk("ss_at_rise", ss, exp_dummy);
      chk("mosi_at_rise", mosi, (!exp_dummy && rises < 48) ? exp_cmd[47 - rises] : 1'b1);
      rises++;
    end
    if (ready) chk("idle_pins", {sck, ss, mosi}, 3'b011);
    if (done) done_cnt++;
    sck_prev = sck;
    idx = rises - 48;
    miso = (!exp_dummy && !ss && idx >= 0 && idx < resp.size()) ? resp[idx] : 1'b1;
  end

  // nff: 0xFF bytes before R1; nff<0 means the card never answers
  task automatic run(input logic [47:0] c, input logic rl, input logic dm, input int nff,
                     input logic [7:0] r1v, input logic [31:0] trl, input logic glitch);
    int polled, exp_rises, base, n, d0;
    logic to;
    to = !dm && (nff < 0 || nff >= NCR);
    polled = to ? NCR : nff + 1;
    exp_rises = dm ? IC : 48 + 8 * polled + ((rl && !to) ? 32 : 0) + 8;
    base = exp_rises * 2 * D;
    resp.delete();
    if (!dm && !to) begin
      for (int i = 0; i < nff; i++) for (int b = 0; b < 8; b++) resp.push_back(1'b1);
      for (int b = 7; b >= 0; b--) resp.push_back(r1v[b]);
      if (rl) for (int b = 31; b >= 0; b--) resp.push_back(trl[b]);
    end
    exp_cmd = c;
    exp_dummy = dm;
    d0 = done_cnt;
    @(negedge clk);
    cmd = c; rsplen = rl; dummy = dm; valid = 1'b1;
    @(posedge clk);
    n = 0;
    while (n < 5000) begin
      @(negedge clk);
      valid = glitch && rises == 60;
      dummy = valid;
      cmd = valid ? 48'h0 : cmd;
      if (done) break;
      @(posedge clk);
      n++;
    end
    valid = 1'b0; dummy = 1'b0;
    if (n >= 5000) begin
      nvec++; nerr++;
      $display("FAIL done_wait: no done within %0d cycles", n);
    end
    nvec++;
    if (n < base || n > base + 3) begin
      nerr++;
      $display("FAIL latency: got %0d expected %0d..%0d", n, base, base + 3);
    end
    last_n = n;
    last_rises = rises;
    chk("sck_rises", rises, exp_rises);
    if (!dm) begin
      exp_r1 = to ? 8'hFF : r1v;
      if (rl && !to) exp_data = trl;
    end
    exp_to = to;
    chk("r1", r1, exp_r1);
    chk("data", data, exp_data);
    chk("timeout", tmo, exp_to);
    @(negedge clk);
    chk("done_width", done, 1'b0);
    chk("ready_after", ready, 1'b1);
    repeat (3) @(negedge clk);
    chk("done_pulses", done_cnt - d0, 1);
    chk("r1_hold", r1, exp_r1);
  endtask

  initial begin
    int w;
    // 1: reset with valid held high
    valid = 1'b1; cmd = 48'h400000000095;
    repeat (4) @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_pins", {sck, ss, mosi}, 3'b011);
    chk("rst_r1", r1, 8'h00);
    chk("rst_data", data, 32'h0);
    chk("rst_done_to", {done, tmo}, 2'b00);
    valid = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_ready", ready, 1'b1);
    // 2: CMD0, one 0xFF byte then R1=0x01
    run(48'h400000000095, 1'b0, 1'b0, 1, 8'h01, 32'h0, 1'b0);
    chk("cmd0_latency_lit", last_n, 576);
    chk("cmd0_r1_lit", r1, 8'h01);
    // 3: CMD8 with R7 trailer
    run(48'h48000001AA87, 1'b1, 1'b0, 0, 8'h01, 32'h000001AA, 1'b0);
    chk("cmd8_data_lit", data, 32'h000001AA);
    // 4: card silent, trailer skipped
    run(48'h7A0000000001, 1'b1, 1'b0, -1, 8'h00, 32'h0, 1'b0);
    chk("ncr_rises_lit", last_rises, 184);
    chk("ncr_to_lit", {r1, tmo}, {8'hFF, 1'b1});
    // 5: dummy clock train
    run(48'h0, 1'b0, 1'b1, 0, 8'h00, 32'h0, 1'b0);
    chk("dummy_rises_lit", last_rises, 80);
    chk("dummy_data_lit", data, 32'h000001AA);
    // boundary: R1 in last allowed byte, with valid pulsed mid-POLL
    run(48'h770000000065, 1'b0, 1'b0, NCR - 1, 8'h00, 32'h0, 1'b1);
    run(48'h4900000000AF, 1'b1, 1'b0, 2, 8'h05, 32'hC0FF_EE12, 1'b0);
    // 6: reset at bit 20 of SEND
    exp_cmd = 48'h400000000095; exp_dummy = 1'b0; resp.delete();
    w = done_cnt;
    @(negedge clk);
    cmd = 48'h400000000095; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    for (int i = 0; i < 2000 && rises < 20; i++) @(negedge clk);
    chk("reach_bit20", rises, 20);
    rst = 1'b1;
    #1;
    chk("abort_ss", ss, 1'b1);
    chk("abort_sck", sck, 1'b0);
    chk("abort_ready", ready, 1'b1);
    exp_r1 = 8'h00; exp_data = 32'h0; exp_to = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_outputs", {r1, data, tmo}, 41'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_no_done", done_cnt - w, 0);
    run(48'h400000000095, 1'b0, 1'b0, 0, 8'h01, 32'h0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
